// File: rtl/branch_resolve_queue.sv
// In-flight branch queue: records fetch-time predictions and checks them in order at resolve,
// producing predictor training pulses and fetch redirects on mispredicts.
module branch_resolve_queue #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_valid,
   input  logic [31:0]                push_pc,
   input  logic                       push_predicted,
   input  logic [31:0]                push_target,
   input  logic                       resolve_valid,
   input  logic                       resolve_taken,
   input  logic [31:0]                resolve_target,
   output logic                       update_valid,
   output logic [31:0]                update_pc,
   output logic                       update_taken,
   output logic                       mispredict,
   output logic [31:0]                redirect_pc,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       error
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      pc_mem   [DEPTH];
   logic             pred_mem [DEPTH];
   logic [31:0]      tgt_mem  [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;

   logic [31:0]      head_pc;
   logic             head_pred;
   logic [31:0]      head_tgt;
   logic             do_resolve;
   logic             mis;
   logic             do_push;
   logic             push_err;
   logic             resolve_err;
   logic [31:0]      redirect_next;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   assign head_pc   = pc_mem[head];
   assign head_pred = pred_mem[head];
   assign head_tgt  = tgt_mem[head];

   // A mispredict makes any same-cycle push wrong-path, so it is dropped silently.
   always_comb begin
      do_resolve    = resolve_valid && !empty;
      mis           = do_resolve &&
                      ((head_pred != resolve_taken) ||
                       (head_pred && resolve_taken && (head_tgt != resolve_target)));
      do_push       = push_valid && !mis && (!full || do_resolve);
      push_err      = push_valid && full && !do_resolve;
      resolve_err   = resolve_valid && empty;
      redirect_next = resolve_taken ? resolve_target : (head_pc + 32'd4);
   end

   always_ff @(posedge clk) begin
      if (rst_n && do_push) begin
         pc_mem[tail]   <= push_pc;
         pred_mem[tail] <= push_predicted;
         tgt_mem[tail]  <= push_target;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         error        <= 1'b0;
         update_valid <= 1'b0;
         update_pc    <= '0;
         update_taken <= 1'b0;
         mispredict   <= 1'b0;
         redirect_pc  <= '0;
      end else begin
         if (mis) begin
            head  <= tail;
            count <= '0;
         end else begin
            if (do_push)    tail <= tail + PTR_W'(1);
            if (do_resolve) head <= head + PTR_W'(1);
            case ({do_push, do_resolve})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end

         if (push_err || resolve_err) error <= 1'b1;

         update_valid <= do_resolve;
         mispredict   <= mis;
         if (do_resolve) begin
            update_pc    <= head_pc;
            update_taken <= resolve_taken;
            redirect_pc  <= redirect_next;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: hand-computed vectors, one checking task, one summary line.
module tb_branch_resolve_queue;

   localparam int DEPTH = 8;

   logic        clk;
   logic        rst_n;
   logic        push_valid;
   logic [31:0] push_pc;
   logic        push_predicted;
   logic [31:0] push_target;
   logic        resolve_valid;
   logic        resolve_taken;
   logic [31:0] resolve_target;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        full;
   logic        empty;
   logic [$clog2(DEPTH):0] count;
   logic        error;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_q[$];
   logic [31:0] exp_pc;

   branch_resolve_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .push_valid(push_valid),
      .push_pc(push_pc),
      .push_predicted(push_predicted),
      .push_target(push_target),
      .resolve_valid(resolve_valid),
      .resolve_taken(resolve_taken),
      .resolve_target(resolve_target),
      .update_valid(update_valid),
      .update_pc(update_pc),
      .update_taken(update_taken),
      .mispredict(mispredict),
      .redirect_pc(redirect_pc),
      .full(full),
      .empty(empty),
      .count(count),
      .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, waits for the edge, then idles the inputs so sampling is clean.
   task automatic applyStimulus(input logic pv, input logic [31:0] ppc, input logic ppred,
                                input logic [31:0] ptgt, input logic rv, input logic rt,
                                input logic [31:0] rtgt);
      push_valid     = pv;
      push_pc        = ppc;
      push_predicted = ppred;
      push_target    = ptgt;
      resolve_valid  = rv;
      resolve_taken  = rt;
      resolve_target = rtgt;
      @(posedge clk);
      #1;
      push_valid    = 1'b0;
      resolve_valid = 1'b0;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic pushEntry(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
      applyStimulus(1'b1, pc, pred, tgt, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic resolveEntry(input logic taken, input logic [31:0] tgt);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, taken, tgt);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      idleCycle();
      idleCycle();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      push_valid = 1'b0; push_pc = '0; push_predicted = 1'b0; push_target = '0;
      resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;

      // Reset state
      doReset();
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_error", 32'(error), 32'd0);
      checkOutput("rst_uvalid", 32'(update_valid), 32'd0);
      checkOutput("rst_mispred", 32'(mispredict), 32'd0);
      checkOutput("rst_upc", update_pc, 32'h0);
      checkOutput("rst_redirect", redirect_pc, 32'h0);

      // Correct not-taken prediction
      pushEntry(32'h100, 1'b0, 32'h0);
      checkOutput("c1_count", 32'(count), 32'd1);
      checkOutput("c1_empty", 32'(empty), 32'd0);
      resolveEntry(1'b0, 32'h0);
      checkOutput("c1_uvalid", 32'(update_valid), 32'd1);
      checkOutput("c1_upc", update_pc, 32'h100);
      checkOutput("c1_utaken", 32'(update_taken), 32'd0);
      checkOutput("c1_mispred", 32'(mispredict), 32'd0);
      checkOutput("c1_empty_after", 32'(empty), 32'd1);
      idleCycle();
      checkOutput("c1_uvalid_drop", 32'(update_valid), 32'd0);
      checkOutput("c1_upc_hold", update_pc, 32'h100);

      // Direction mispredict squashes younger entries and a same-cycle push
      pushEntry(32'h100, 1'b0, 32'h0);
      pushEntry(32'h108, 1'b0, 32'h0);
      pushEntry(32'h110, 1'b0, 32'h0);
      checkOutput("m1_count3", 32'(count), 32'd3);
      applyStimulus(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
      checkOutput("m1_mispred", 32'(mispredict), 32'd1);
      checkOutput("m1_redirect", redirect_pc, 32'h200);
      checkOutput("m1_uvalid", 32'(update_valid), 32'd1);
      checkOutput("m1_utaken", 32'(update_taken), 32'd1);
      checkOutput("m1_count0", 32'(count), 32'd0);
      checkOutput("m1_empty", 32'(empty), 32'd1);
      checkOutput("m1_error", 32'(error), 32'd0);
      idleCycle();
      checkOutput("m1_mispred_drop", 32'(mispredict), 32'd0);

      // Predicted taken, actually not taken
      pushEntry(32'h40, 1'b1, 32'h80);
      resolveEntry(1'b0, 32'h0);
      checkOutput("m2_mispred", 32'(mispredict), 32'd1);
      checkOutput("m2_redirect", redirect_pc, 32'h44);

      // Taken with wrong target
      pushEntry(32'h40, 1'b1, 32'h80);
      resolveEntry(1'b1, 32'h90);
      checkOutput("m3_mispred", 32'(mispredict), 32'd1);
      checkOutput("m3_redirect", redirect_pc, 32'h90);

      // Taken with matching target is correct
      pushEntry(32'h40, 1'b1, 32'h80);
      resolveEntry(1'b1, 32'h80);
      checkOutput("c2_mispred", 32'(mispredict), 32'd0);
      checkOutput("c2_uvalid", 32'(update_valid), 32'd1);

      // Not-taken mispredict at top of address space wraps pc+4
      pushEntry(32'hFFFF_FFFC, 1'b1, 32'h10);
      resolveEntry(1'b0, 32'h0);
      checkOutput("m4_redirect_wrap", redirect_pc, 32'h0);

      // Simultaneous push and correct resolve keeps count
      pushEntry(32'h500, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h504, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("s1_upc", update_pc, 32'h500);
      checkOutput("s1_count", 32'(count), 32'd1);
      resolveEntry(1'b0, 32'h0);
      checkOutput("s1_upc2", update_pc, 32'h504);

      // Fill, then stream push+resolve while full across pointer wrap
      doReset();
      model_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         pushEntry(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
         model_q.push_back(32'h1000 + 32'(4 * i));
      end
      checkOutput("f_full", 32'(full), 32'd1);
      checkOutput("f_count", 32'(count), 32'(DEPTH));
      for (int i = 0; i < 3 * DEPTH; i++) begin
         applyStimulus(1'b1, 32'h2000 + 32'(4 * i), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
         exp_pc = model_q.pop_front();
         model_q.push_back(32'h2000 + 32'(4 * i));
         checkOutput("w_upc", update_pc, exp_pc);
         checkOutput("w_count", 32'(count), 32'(DEPTH));
      end
      checkOutput("w_error", 32'(error), 32'd0);
      pushEntry(32'hDEAD_0000, 1'b0, 32'h0);
      checkOutput("ovf_error", 32'(error), 32'd1);
      checkOutput("ovf_count", 32'(count), 32'(DEPTH));
      // Back-to-back drain keeps FIFO order and pulses every cycle
      for (int i = 0; i < DEPTH; i++) begin
         resolveEntry(1'b0, 32'h0);
         exp_pc = model_q.pop_front();
         checkOutput("d_uvalid", 32'(update_valid), 32'd1);
         checkOutput("d_upc", update_pc, exp_pc);
      end
      checkOutput("d_empty", 32'(empty), 32'd1);

      // Resolve on empty
      doReset();
      resolveEntry(1'b0, 32'h0);
      checkOutput("e_uvalid", 32'(update_valid), 32'd0);
      checkOutput("e_error", 32'(error), 32'd1);
      idleCycle();
      idleCycle();
      checkOutput("e_error_sticky", 32'(error), 32'd1);
      doReset();
      checkOutput("e_error_clear", 32'(error), 32'd0);

      // Reset coincident with a resolve discards everything
      pushEntry(32'h700, 1'b0, 32'h0);
      pushEntry(32'h704, 1'b0, 32'h0);
      pushEntry(32'h708, 1'b0, 32'h0);
      rst_n = 1'b0;
      resolveEntry(1'b1, 32'h900);
      checkOutput("r_uvalid", 32'(update_valid), 32'd0);
      checkOutput("r_mispred", 32'(mispredict), 32'd0);
      checkOutput("r_empty", 32'(empty), 32'd1);
      checkOutput("r_count", 32'(count), 32'd0);
      checkOutput("r_error", 32'(error), 32'd0);
      rst_n = 1'b1;
      idleCycle();
      checkOutput("r_uvalid_after", 32'(update_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 Parameter: DEPTH, default 8, number of in-flight branch entries (power of two, 2..16).
REQ-002 Port: clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low; one clock, reset synchronous active-low.
REQ-004 Port: push_valid  input  1  fetch stage enqueues a predicted branch this cycle.
REQ-005 Port: push_pc  input  32  branch PC at fetch.
REQ-006 Port: push_predicted  input  1  direction from the 2-level predictor (1 = taken).
REQ-007 Port: push_target  input  32  predicted target used by fetch when push_predicted=1.
REQ-008 Port: resolve_valid  input  1  mem stage resolves the oldest branch this cycle.
REQ-009 Port: resolve_taken  input  1  actual branch outcome.
REQ-010 Port: resolve_target  input  32  actual taken target.
REQ-011 Port: update_valid  output  1  one-cycle pulse: predictor training request.
REQ-012 Port: update_pc  output  32  PC of the resolved branch (drives the predictor's update PC).
REQ-013 Port: update_taken  output  1  actual outcome (drives the predictor's outcome input).
REQ-014 Port: mispredict  output  1  one-cycle pulse: fetch must redirect and squash.
REQ-015 Port: redirect_pc  output  32  correct next PC, valid while mispredict=1.
REQ-016 Port: full, empty  output  1 each  queue status, reflecting state after the last edge.
REQ-017 Port: count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-018 Port: error  output  1  sticky: overflow push or resolve-while-empty seen.

Function
REQ-019 Storage: circular FIFO of DEPTH entries {pc, predicted, target}; head = oldest, tail = next free; pointers wrap modulo DEPTH.
REQ-020 Push: when push_valid=1 and full=0 and no mispredict is detected this cycle, entry written at tail, tail+1, count+1.
REQ-021 Push when full (no simultaneous pop): entry dropped, state unchanged, error set.
REQ-022 Resolve: when resolve_valid=1 and empty=0, head entry compared and popped at the same edge.
REQ-023 Resolve when empty: ignored (no update, no mispredict), error set.
REQ-024 Mispredict condition: predicted != resolve_taken, OR (predicted=1 AND resolve_taken=1 AND target != resolve_target).
REQ-025 redirect_pc = resolve_target if resolve_taken=1, else entry pc + 4 (32-bit, wraps modulo 2^32).
REQ-026 Latency: update_valid/update_pc/update_taken/mispredict/redirect_pc registered, asserted the cycle after the resolving edge, held for exactly one cycle; pc/taken hold last value otherwise.
REQ-027 update_valid pulses for every valid resolve, mispredicted or not.
REQ-028 Mispredict squash: at the resolving edge all entries younger than head are discarded: head=tail, count=0; a push in that same cycle is dropped (wrong-path) without setting error.
REQ-029 Simultaneous push and correct resolve: both occur; count unchanged; allowed when full (pop frees the slot, push is accepted, no error).
REQ-030 Back-to-back resolves each cycle supported; outputs pulse in consecutive cycles.
REQ-031 full = (count==DEPTH); empty = (count==0); never both 1.

Reset
REQ-032 When rst_n=0 at a rising edge: head=tail=0, count=0, empty=1, full=0, error=0, update_valid=0, mispredict=0, update_pc=0, update_taken=0, redirect_pc=0.
REQ-033 Reset dominates same-cycle push/resolve; entries pending mid-operation are discarded and no pulse follows reset.
REQ-034 Entry storage contents need not be reset.

Verification
REQ-035 Correct prediction: push pc=0x100, pred=0; next cycle resolve taken=0 -> following cycle update_valid=1, update_pc=0x100, update_taken=0, mispredict=0, empty=1.
REQ-036 Direction mispredict with younger entries: push 0x100(pred=0), 0x108, 0x110; resolve taken=1, target=0x200 -> mispredict=1, redirect_pc=0x200, count=0 after edge.
REQ-037 Not-taken mispredict and target mismatch: push 0x40(pred=1,target=0x80), resolve taken=0 -> redirect_pc=0x44; push 0x40(pred=1,target=0x80), resolve taken=1,target=0x90 -> mispredict=1, redirect_pc=0x90.
REQ-038 Fill/wrap: push DEPTH entries -> full=1; extra push -> error=1, count=DEPTH; push+correct resolve together while full -> accepted, FIFO order preserved across pointer wrap for 3*DEPTH entries.
REQ-039 Resolve on empty -> no update_valid, error=1 sticky until rst_n=0.
REQ-040 Reset mid-stream: 3 entries queued, rst_n=0 coincident with resolve -> no pulse next cycle, empty=1, count=0, error=0.
